mdu_ctrl: RTL and testbench



---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_calc.sv | 55 +++++
 rtl/mdu_ctrl.sv | 120 ++++++++++++
 tb/tb_mdu_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDUOp encodings, FSM states
// and default operation latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic is_arith(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator for mult/multu/div/divu; produces the HI/LO
// pair that is later committed by the controller.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] sa,
  input  logic [31:0] sb,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{sa[31]}}, sa} * {{32{sb[31]}}, sb};
  assign prod_u = {32'd0, sa} * {32'd0, sb};

  // Signed divide works on magnitudes, so 0x80000000 / -1 wraps to 0x80000000.
  assign signed_div = (op == MDU_DIV);
  assign abs_a      = (signed_div && sa[31]) ? -sa : sa;
  assign abs_b      = (signed_div && sb[31]) ? -sb : sb;
  assign divisor    = (sb == 32'd0) ? 32'd1 : abs_b;
  assign q_mag      = abs_a / divisor;
  assign r_mag      = abs_a % divisor;
  assign quot       = (signed_div && (sa[31] ^ sb[31])) ? -q_mag : q_mag;
  assign rem        = (signed_div && sa[31]) ? -r_mag : r_mag;

  assign div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (sb == 32'd0);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      MDU_MULT:           {res_hi, res_lo} = prod_s;
      MDU_MULTU:          {res_hi, res_lo} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        res_hi = rem;
        res_lo = quot;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: sequences fixed-latency operations, owns HI/LO
// and serves mfhi/mflo/mthi/mtlo for the E stage.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] SA,
  input  logic [31:0] SB,
  output logic        start,
  output logic        busy,
  output logic [31:0] MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       pend_hi_q, pend_hi_d;
  logic [31:0]       pend_lo_q, pend_lo_d;
  logic              pend_wr_q, pend_wr_d;

  logic [31:0]       calc_hi;
  logic [31:0]       calc_lo;
  logic              calc_dbz;

  mdu_calc u_calc (
    .op          (MDUOp),
    .sa          (SA),
    .sb          (SB),
    .res_hi      (calc_hi),
    .res_lo      (calc_lo),
    .div_by_zero (calc_dbz)
  );

  assign start = is_arith(MDUOp) && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          cnt_d     = is_mul(MDUOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          pend_hi_d = calc_hi;
          pend_lo_d = calc_lo;
          pend_wr_d = !calc_dbz;
        end else if (MDUOp == MDU_MTHI) begin
          hi_d = SA;
        end else if (MDUOp == MDU_MTLO) begin
          lo_d = SA;
        end
      end
      ST_RUN: begin
        // Divide-by-zero still occupies the unit but leaves HI/LO untouched.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == MDU_MFHI)      MDUOut = hi_q;
    else if (MDUOp == MDU_MFLO) MDUOut = lo_q;
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a driver updates an arithmetic reference model
// and queues expectations; a negedge monitor pops and compares them.
module tb_mdu_ctrl;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  MDUOp = 4'd0;
  logic [31:0] SA = 32'd0;
  logic [31:0] SB = 32'd0;
  logic        start;
  logic        busy;
  logic [31:0] MDUOut;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu_ctrl #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
    .clk    (clk),
    .reset  (reset),
    .MDUOp  (MDUOp),
    .SA     (SA),
    .SB     (SB),
    .start  (start),
    .busy   (busy),
    .MDUOut (MDUOut),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } done_t;

  done_t       done_q[$];
  logic        start_q[$];
  logic [31:0] read_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: committed HI/LO, pending result, remaining busy cycles.
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  bit          m_dz = 0;
  int          m_left = 0;
  int          m_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] ph, output logic [31:0] pl, output bit dz);
    longint          ps, q, r;
    longint unsigned pu;
    ph = 0; pl = 0; dz = 0;
    case (op)
      4'd1: begin ps = longint'($signed(a)) * longint'($signed(b)); ph = ps[63:32]; pl = ps[31:0]; end
      4'd2: begin pu = 64'(a) * 64'(b); ph = pu[63:32]; pl = pu[31:0]; end
      4'd3: begin
        if (b == 0) dz = 1;
        else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          pl = q[31:0]; ph = r[31:0];
        end
      end
      default: begin
        if (b == 0) dz = 1;
        else begin pl = a / b; ph = a % b; end
      end
    endcase
  endfunction

  // One clock cycle of stimulus; the model advances across the same edge.
  task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit arith;
    arith = (op >= 1) && (op <= 4);
    MDUOp = op; SA = a; SB = b;
    if (arith) start_q.push_back(m_left == 0);
    if (op == 4'd5) read_q.push_back(m_hi);
    else if (op == 4'd6) read_q.push_back(m_lo);
    if (m_left > 0) begin
      if (m_left == 1) begin
        if (!m_dz) begin m_hi = m_phi; m_lo = m_plo; end
        done_q.push_back('{m_hi, m_lo, m_len});
      end
      m_left--;
    end else if (arith) begin
      model_op(op, a, b, m_phi, m_plo, m_dz);
      m_len  = (op <= 2) ? NM : ND;
      m_left = m_len;
    end else if (op == 4'd7) m_hi = a;
    else if (op == 4'd8) m_lo = a;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'd0, 32'd0, 32'd0);
  endtask

  task automatic reset_dut();
    reset = 1'b1; MDUOp = 4'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 0; m_lo = 0; m_left = 0; m_dz = 0;
    done_q.delete();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
  endtask

  // Monitor: completion on busy falling edge, start/MDUOut on every E-stage op.
  bit rst_edge = 1'b1;
  bit prev_busy = 1'b0;
  int run_len = 0;

  always @(posedge clk) rst_edge = reset;

  always @(negedge clk) begin
    done_t d;
    if (busy === 1'b1) run_len++;
    if (prev_busy && busy !== 1'b1 && !rst_edge) begin
      if (done_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: busy fell with no operation outstanding at %0t", $time);
      end else begin
        d = done_q.pop_front();
        check("done_hi", HI, d.hi);
        check("done_lo", LO, d.lo);
        check("busy_len", 32'(run_len), 32'(d.len));
        $display("done: HI=0x%08h LO=0x%08h busy=%0d", HI, LO, run_len);
      end
    end
    if (busy !== 1'b1) run_len = 0;
    prev_busy = (busy === 1'b1);
    if (!reset) begin
      if (MDUOp >= 4'd1 && MDUOp <= 4'd4) begin
        if (start_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL start_queue: empty at %0t", $time);
        end else check("start", {31'd0, start}, {31'd0, start_q.pop_front()});
      end
      if (MDUOp == 4'd5 || MDUOp == 4'd6) begin
        if (read_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL read_queue: empty at %0t", $time);
        end else check("mduout", MDUOut, read_q.pop_front());
      end else check("mduout_zero", MDUOut, 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1;
    reset_dut();

    cyc(4'd1, 32'd3, 32'hFFFF_FFFE); idle(NM);
    check("mult_hi", HI, 32'hFFFF_FFFF); check("mult_lo", LO, 32'hFFFF_FFFA);

    cyc(4'd2, 32'hFFFF_FFFF, 32'd2); idle(NM);
    check("multu_hi", HI, 32'h1); check("multu_lo", LO, 32'hFFFF_FFFE);
    MDUOp = 4'd6; #1; check("mflo_out", MDUOut, 32'hFFFF_FFFE);
    cyc(4'd6, 32'd0, 32'd0);

    cyc(4'd3, 32'hFFFF_FFF9, 32'd2); idle(ND);
    check("div_hi", HI, 32'hFFFF_FFFF); check("div_lo", LO, 32'hFFFF_FFFD);
    cyc(4'd4, 32'd7, 32'd2); idle(ND);
    check("divu_hi", HI, 32'd1); check("divu_lo", LO, 32'd3);

    cyc(4'd7, 32'h1234, 32'd0); cyc(4'd8, 32'h5678, 32'd0);
    cyc(4'd3, 32'd5, 32'd0); idle(ND);
    check("dz_hi", HI, 32'h1234); check("dz_lo", LO, 32'h5678);

    cyc(4'd1, 32'd6, 32'd7); cyc(4'd0, 0, 0);
    cyc(4'd1, 32'd1, 32'd1); cyc(4'd8, 32'hDEAD, 0); cyc(4'd5, 0, 0);
    idle(1);
    check("ign_hi", HI, 32'd0); check("ign_lo", LO, 32'd42);

    cyc(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); idle(ND);
    check("ovf_hi", HI, 32'd0); check("ovf_lo", LO, 32'h8000_0000);

    cyc(4'd3, 32'd100, 32'd7); idle(3);
    reset_dut();
    idle(ND + 2);
    cyc(4'd5, 0, 0); cyc(4'd6, 0, 0);
    check("post_rst_hi", HI, 32'd0); check("post_rst_lo", LO, 32'd0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) cyc(4'($urandom_range(0, 15)), pick(), pick());
      else cyc(4'($urandom_range(1, 8)), pick(), pick());
    end
    idle(ND + 2);

    n_cmp++;
    if (done_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d completions never observed, expected 0", done_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
